// File: rtl/seq_detector_param_if.sv
// Bundle for seq_detector_param: configuration strobe and fields, serial input with
// its valid, and the detect pulse and match count.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in_bit;
    logic               detect;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
        input  detect, match_count
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
        output detect, match_count
    );
endinterface

// File: rtl/seq_detector_param.sv
// Run-time programmable Moore bit-sequence detector with registered detect pulse.
// Define SEQ_CNT_EN to build the saturating match counter; otherwise match_count is 0.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input logic                 clk,
    input logic                 reset_n,
    seq_detector_param_if.slave bus
);
    localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(3'b101);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    // The compare window is the stored bits plus the incoming bit, so the oldest bit is never kept.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               det_q, det_d;

    logic [MAX_LEN-1:0] hist_sh;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_inc;
    logic               match;

    function automatic logic [LEN_W-1:0] fill_sat(input logic [LEN_W-1:0] f);
        return (f >= LEN_MAX) ? LEN_MAX : LEN_W'(f + 1'b1);
    endfunction

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    assign hist_sh  = {hist_q, bus.in_bit};
    assign fill_inc = fill_sat(fill_q);
    assign match    = (len_q != '0) && (fill_inc >= len_q) &&
                      (((hist_sh ^ pat_q) & mask) == '0);

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        det_d  = 1'b0;
        if (bus.cfg_load) begin
            pat_d  = bus.cfg_pattern;
            len_d  = (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
            ovl_d  = bus.cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.in_valid) begin
            hist_d = hist_sh[MAX_LEN-2:0];
            // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
            det_d  = match;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q  <= PAT_RST;
            len_q  <= LEN_W'(3);
            ovl_q  <= 1'b0;
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= det_d;
        end
    end

    assign bus.detect = det_q;

`ifdef SEQ_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [CNT_W-1:0] cnt_sat(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? CNT_MAX : CNT_W'(c + 1'b1);
    endfunction

    // Counts on the same edge that raises detect; a load in that cycle clears instead.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cfg_load) begin
            cnt_d = '0;
        end else if (det_d) begin
            cnt_d = cnt_sat(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_count = cnt_q;
`else
    assign bus.match_count = CNT_W'(0);
`endif
endmodule
